sramlike_ram_slave: RTL
=======================

SRAMLIKE_RAM_SLAVE -- requirements
Module: sramlike_ram_slave

Purpose: responder end of the sram-like bus used by the CPU core's inst/data ports; an on-chip word RAM with programmable handshake latency, used as the memory model and boot RAM.

Interface
REQ-001 SHALL have parameter AW, default 12, meaning log2 of the RAM depth in 32-bit words.
REQ-002 SHALL have parameter ADDR_LAT, default 0, meaning the minimum number of cycles `req` is held before `addr_ok` may assert.
REQ-003 SHALL have parameter DATA_LAT, default 2, range >=1, meaning the number of cycles from the accepting edge to `data_ok`.
REQ-004 SHALL have parameter MAX_OUT, default 2, range >=1, meaning the maximum number of accepted-but-unanswered transactions.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 req  in  1  request valid; held by the initiator until accepted.
REQ-008 wr  in  1  1 = write, 0 = read.
REQ-009 size  in  2  00 = byte, 01 = halfword, 10 = word; 11 is treated as word.
REQ-010 addr  in  32  byte address.
REQ-011 wdata  in  32  write data, already lane-aligned to its byte position.
REQ-012 addr_ok  out  1  request accepted on a rising edge where req&addr_ok.
REQ-013 data_ok  out  1  one-cycle response pulse, one per accepted transaction, in acceptance order.
REQ-014 rdata  out  32  read word, valid only while data_ok is high.

Function
REQ-015 Word index SHALL be addr[AW+1:2]; upper address bits SHALL be ignored, so aliasing is permitted.
REQ-016 Byte enables SHALL be:
- size 00: 4'b0001<<addr[1:0]
- size 01: 4'b0011<<{addr[1],1'b0} (addr[0] ignored)
- size 10/11: 4'b1111
REQ-017 A wait counter SHALL increment each cycle req=1 without acceptance, saturating at ADDR_LAT, and SHALL clear on acceptance or when req=0.
REQ-018 addr_ok SHALL equal req & (count<MAX_OUT) & (wait_cnt>=ADDR_LAT); with ADDR_LAT=0 this is combinational on req.
REQ-019 When the queue is full, addr_ok SHALL be 0 even if a pop occurs in the same cycle (no full bypass).
REQ-020 On acceptance of a write, the RAM SHALL update the enabled byte lanes from wdata at that same edge.
REQ-021 On acceptance of a read, the full RAM word (pre-edge contents) SHALL be captured into the queue entry; later writes SHALL NOT alter it.
REQ-022 Each queue entry SHALL hold {wr, captured data, countdown}; countdown SHALL load DATA_LAT-1 on acceptance and decrement each cycle while nonzero.
REQ-023 data_ok SHALL be 1 in a cycle when the queue is non-empty and the head countdown equals 0; the head SHALL pop at that edge.
REQ-024 Result: acceptance at edge t produces data_ok during the cycle following edge t+DATA_LAT-1.
REQ-025 rdata SHALL equal the head captured word for reads, 0 for writes, and 0 whenever data_ok=0.
REQ-026 Simultaneous accept and pop when not full SHALL both take effect; occupancy stays unchanged.
REQ-027 Queue pointers SHALL wrap modulo MAX_OUT.
REQ-028 In-order completion SHALL be guaranteed, since all entries share the same latency.

Reset
REQ-029 While rst=0, addr_ok, data_ok and rdata SHALL be 0, and the queue, pointers, count and wait counter SHALL be cleared.
REQ-030 RAM contents SHALL NOT be reset.
REQ-031 Reset asserted mid-operation SHALL discard pending responses; no data_ok for pre-reset transactions SHALL appear after release.

Verification
REQ-032 Word write then read (defaults):
- write 0x12345678 to 0x100, then read 0x100 accepted at edge t
- -> data_ok=1 in the cycle after edge t+1, rdata=0x12345678
REQ-033 Byte write:
- word 0x100 holds 0x11223344; write size=00, addr=0x101, wdata=0x0000AB00; read 0x100
- -> rdata=0x1122AB44
REQ-034 Queue full:
- three reads requested on consecutive cycles, MAX_OUT=2
- -> addr_ok low for the third until the first data_ok edge
- -> data_ok pulses return the three words in order
REQ-035 ADDR_LAT=3:
- req rises in cycle 0 and is held
- -> addr_ok first high in cycle 3; wait counter clears after acceptance
REQ-036 Read-before-write:
- read 0x200 (holds 0xDEADBEEF) accepted, then write 0xCAFEF00D to 0x200 on the next edge
- -> read rdata=0xDEADBEEF; write data_ok rdata=0; a later read returns 0xCAFEF00D
REQ-037 Reset with 2 outstanding:
- assert rst=0 for 2 cycles
- -> no data_ok; addr_ok=0 during reset
- -> a fresh read after release completes with DATA_LAT timing

Source files
------------

// File: rtl/sramlike_ram_slave.sv
// sramlike_ram_slave
//   Responder end of the sram-like bus: an on-chip word RAM with programmable
//   address-phase and data-phase latency. Used as memory model and boot RAM.
//
// Parameters
//   AW        log2 of RAM depth in 32-bit words
//   ADDR_LAT  minimum cycles req is held before addr_ok may assert
//   DATA_LAT  cycles from the accepting edge to data_ok (>= 1)
//   MAX_OUT   maximum accepted-but-unanswered transactions (>= 1)
//
// Ports
//   clk      single clock, rising edge
//   rst      asynchronous active-low reset
//   req      request valid, held by the initiator until accepted
//   wr       1 = write, 0 = read
//   size     00 byte, 01 halfword, 10/11 word
//   addr     byte address
//   wdata    write data, already lane-aligned
//   addr_ok  request accepted on a rising edge where req & addr_ok
//   data_ok  one-cycle response pulse per accepted transaction, in order
//   rdata    read word, zero unless data_ok is high for a read
module sramlike_ram_slave #(
   parameter int unsigned AW       = 12,
   parameter int unsigned ADDR_LAT = 0,
   parameter int unsigned DATA_LAT = 2,
   parameter int unsigned MAX_OUT  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   localparam int unsigned Depth = 1 << AW;
   localparam int unsigned WaitW = (ADDR_LAT > 0) ? $clog2(ADDR_LAT + 1) : 1;
   localparam int unsigned CdW   = (DATA_LAT > 1) ? $clog2(DATA_LAT) : 1;
   localparam int unsigned PtrW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int unsigned CntW  = $clog2(MAX_OUT + 1);

   localparam logic [WaitW-1:0] WaitMax = WaitW'(ADDR_LAT);
   localparam logic [CdW-1:0]   CdInit  = CdW'(DATA_LAT - 1);
   localparam logic [CntW-1:0]  CntMax  = CntW'(MAX_OUT);
   localparam logic [PtrW-1:0]  PtrLast = PtrW'(MAX_OUT - 1);

   // Storage (never reset)
   logic [31:0] mem [Depth];

   // Response queue
   logic            wr_q   [MAX_OUT];
   logic [31:0]     data_q [MAX_OUT];
   logic [CdW-1:0]  cd_q   [MAX_OUT];
   logic [PtrW-1:0] head_q;
   logic [PtrW-1:0] tail_q;
   logic [CntW-1:0] count_q;
   logic [WaitW-1:0] wait_q;

   logic [AW-1:0] idx;
   logic [3:0]    be;
   logic [31:0]   rd_word;
   logic          accept;
   logic          pop;
   logic          unused_addr;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrLast) ? '0 : p + 1'b1;
   endfunction

   assign idx         = addr[AW+1:2];
   assign unused_addr = ^addr[31:AW+2];
   assign rd_word     = mem[idx];

   always_comb begin
      be = 4'b1111;
      unique case (size)
         2'b00:        be = 4'b0001 << addr[1:0];
         2'b01:        be = 4'b0011 << {addr[1], 1'b0};
         2'b10, 2'b11: be = 4'b1111;
         default:      be = 4'b1111;
      endcase
   end

   // The wait counter saturates at WaitMax, so equality is the threshold test.
   // A full queue blocks acceptance even if the head pops this cycle.
   assign addr_ok = rst & req & (count_q < CntMax) & (wait_q == WaitMax);
   assign accept  = addr_ok;

   assign pop     = (count_q != '0) && (cd_q[head_q] == '0);
   assign data_ok = pop;
   assign rdata   = (pop && !wr_q[head_q]) ? data_q[head_q] : 32'h0;

   always_ff @(posedge clk) begin
      if (accept && wr) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         wait_q  <= '0;
         for (int i = 0; i < int'(MAX_OUT); i++) begin
            wr_q[i]   <= 1'b0;
            data_q[i] <= '0;
            cd_q[i]   <= '0;
         end
      end else begin
         if (!req || accept) begin
            wait_q <= '0;
         end else if (wait_q != WaitMax) begin
            wait_q <= wait_q + 1'b1;
         end

         // Every entry shares one latency, so all countdowns run in lockstep.
         for (int i = 0; i < int'(MAX_OUT); i++) begin
            if (cd_q[i] != '0) cd_q[i] <= cd_q[i] - 1'b1;
         end

         if (accept) begin
            wr_q[tail_q]   <= wr;
            // Read data is captured from the pre-edge word so later writes cannot alter it.
            data_q[tail_q] <= wr ? 32'h0 : rd_word;
            cd_q[tail_q]   <= CdInit;
            tail_q         <= ptr_inc(tail_q);
         end

         if (pop) head_q <= ptr_inc(head_q);

         unique case ({accept, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule
